// File: rtl/board_pkg.sv
// board_pkg: shared overlay modes, default board geometry and colours for the board drawing stages.
package board_pkg;
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_OUTLINE = 2'd3;
  localparam int X0_DEF = 0;
  localparam int Y0_DEF = 0;
  localparam int CELL_W_DEF = 341;
  localparam int CELL_H_DEF = 256;
  localparam int GAP_DEF = 4;
  localparam int IDX_W = 2;
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_RED = 12'hF00;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;
endpackage

// File: rtl/board_cell_locate.sv
// board_cell_locate: comparator bank finding which cell along one axis holds a pixel, and its offset from the cell edge.
module board_cell_locate
  import board_pkg::*;
#(
  parameter int ORIGIN = 0,
  parameter int PITCH = 341,
  parameter int GAP = 4,
  parameter int COUNT = 3
) (
  input  logic [10:0]      pos,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic [10:0]      off
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    off = '0;
    for (int i = 0; i < COUNT; i++)
      if (int'(pos) >= ORIGIN + i*PITCH + GAP && int'(pos) <= ORIGIN + (i+1)*PITCH - 1) begin
        idx = IDX_W'(i);
        found = 1'b1;
        off = 11'(int'(pos) - (ORIGIN + i*PITCH));
      end
  end
endmodule

// File: rtl/draw_board_cells.sv
// draw_board_cells: paints a per-frame selected subset of board cells (solid, blinking or outlined) onto the pixel stream with 2-cycle latency.
module draw_board_cells
  import board_pkg::*;
#(
  parameter int GRID_N = 3,
  parameter int X0 = X0_DEF,
  parameter int Y0 = Y0_DEF,
  parameter int CELL_W = CELL_W_DEF,
  parameter int CELL_H = CELL_H_DEF,
  parameter int GAP = GAP_DEF,
  parameter int OUTLINE_W = 6,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [10:0]                hcount_in,
  input  logic [10:0]                vcount_in,
  input  logic                       hsync_in,
  input  logic                       hblnk_in,
  input  logic                       vsync_in,
  input  logic                       vblnk_in,
  input  logic [11:0]                rgb_in,
  input  logic                       start_en,
  input  logic                       choice_en,
  input  logic [GRID_N*GRID_N-1:0]   cell_en,
  input  logic [1:0]                 mode,
  input  logic [11:0]                square_color,
  output logic [10:0]                hcount_out,
  output logic [10:0]                vcount_out,
  output logic                       hsync_out,
  output logic                       hblnk_out,
  output logic                       vsync_out,
  output logic                       vblnk_out,
  output logic [11:0]                rgb_out,
  output logic [3:0]                 cell_idx_out,
  output logic                       cell_hit_out
);
  localparam int CELLS = GRID_N*GRID_N;
  localparam int CW = $clog2(BLINK_FRAMES) + 1;
  logic [CELLS-1:0] sh_cell_en;
  logic [1:0] sh_mode;
  logic [11:0] sh_color;
  logic sh_ov_en;
  logic [CW-1:0] blink_cnt;
  logic phase;
  logic [10:0] s1_hc, s1_vc, s1_dx, s1_dy;
  logic s1_hs, s1_hb, s1_vs, s1_vb, s1_hit;
  logic [11:0] s1_rgb;
  logic [IDX_W-1:0] s1_col, s1_row;
  logic [IDX_W-1:0] h_idx, v_idx;
  logic h_found, v_found;
  logic [10:0] h_off, v_off;
  logic vb_rise, vs_rise, blink_wrap;
  logic [3:0] idx;
  logic [15:0] en_pad;
  logic sel, on_edge, paint;
  logic [11:0] rgb_next;

  board_cell_locate #(.ORIGIN(X0), .PITCH(CELL_W), .GAP(GAP), .COUNT(GRID_N)) u_loc_h (
    .pos(hcount_in), .idx(h_idx), .found(h_found), .off(h_off)
  );
  board_cell_locate #(.ORIGIN(Y0), .PITCH(CELL_H), .GAP(GAP), .COUNT(GRID_N)) u_loc_v (
    .pos(vcount_in), .idx(v_idx), .found(v_found), .off(v_off)
  );

  // The stage-1 copies of vblnk/vsync double as the previous-cycle samples for edge detection.
  assign vb_rise = vblnk_in & ~s1_vb;
  assign vs_rise = vsync_in & ~s1_vs;
  assign blink_wrap = blink_cnt == CW'(BLINK_FRAMES - 1);

  always_comb begin
    idx = {2'b00, s1_row} * 4'(GRID_N) + {2'b00, s1_col};
    en_pad = 16'(sh_cell_en);
    sel = s1_hit & sh_ov_en & en_pad[idx];
    on_edge = s1_dx < 11'(OUTLINE_W) || s1_dy < 11'(OUTLINE_W) ||
              s1_dx >= 11'(CELL_W - GAP - OUTLINE_W) || s1_dy >= 11'(CELL_H - GAP - OUTLINE_W);
    paint = sel & ((sh_mode == MODE_SOLID) | ((sh_mode == MODE_BLINK) & phase) |
                   ((sh_mode == MODE_OUTLINE) & on_edge));
    rgb_next = paint ? sh_color : s1_rgb;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      sh_cell_en <= '0;
      sh_mode <= MODE_OFF;
      sh_color <= COLOR_BLACK;
      sh_ov_en <= 1'b0;
      blink_cnt <= '0;
      phase <= 1'b1;
      {s1_hc, s1_vc, s1_dx, s1_dy} <= '0;
      {s1_hs, s1_hb, s1_vs, s1_vb, s1_hit} <= '0;
      s1_rgb <= COLOR_BLACK;
      s1_col <= '0;
      s1_row <= '0;
      {hcount_out, vcount_out} <= '0;
      {hsync_out, hblnk_out, vsync_out, vblnk_out} <= '0;
      rgb_out <= COLOR_BLACK;
      cell_idx_out <= '0;
      cell_hit_out <= 1'b0;
    end else begin
      if (vb_rise) begin
        sh_cell_en <= cell_en;
        sh_mode <= mode;
        sh_color <= square_color;
        sh_ov_en <= start_en & ~choice_en;
      end
      if (vs_rise) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + CW'(1);
        phase <= blink_wrap ? ~phase : phase;
      end
      s1_hc <= hcount_in;
      s1_vc <= vcount_in;
      s1_hs <= hsync_in;
      s1_hb <= hblnk_in;
      s1_vs <= vsync_in;
      s1_vb <= vblnk_in;
      s1_rgb <= rgb_in;
      s1_col <= h_idx;
      s1_row <= v_idx;
      s1_dx <= h_off;
      s1_dy <= v_off;
      s1_hit <= h_found & v_found & ~hblnk_in & ~vblnk_in;
      hcount_out <= s1_hc;
      vcount_out <= s1_vc;
      hsync_out <= s1_hs;
      hblnk_out <= s1_hb;
      vsync_out <= s1_vs;
      vblnk_out <= s1_vb;
      rgb_out <= rgb_next;
      cell_idx_out <= s1_hit ? idx : 4'd0;
      cell_hit_out <= s1_hit;
    end
  end
endmodule

// File: tb/tb_draw_board_cells.sv
// tb_draw_board_cells: directed pixel vectors checked against an arithmetic board model and hand-computed expectations.
module tb_draw_board_cells;
  import board_pkg::*;
  localparam int N = 3, CW = 341, CH = 256, G = 4, OW = 6, BF = 2;

  typedef struct packed {
    logic [10:0] hc, vc;
    logic hs, hb, vs, vb;
    logic [11:0] rgb;
    logic [3:0] idx;
    logic hit;
  } out_t;

  logic pclk = 0, rst = 0;
  logic [10:0] hcount_in = 0, vcount_in = 0;
  logic hsync_in = 0, hblnk_in = 0, vsync_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = 0, square_color = 0;
  logic start_en = 0, choice_en = 0;
  logic [8:0] cell_en = 0;
  logic [1:0] mode = 0;
  logic [10:0] hcount_out, vcount_out;
  logic hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [3:0] cell_idx_out;
  logic cell_hit_out;

  int checks = 0, errors = 0;
  bit live = 0;

  always #5 pclk = ~pclk;

  draw_board_cells #(.BLINK_FRAMES(BF)) dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en), .cell_en(cell_en),
    .mode(mode), .square_color(square_color), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .cell_idx_out(cell_idx_out), .cell_hit_out(cell_hit_out)
  );

  // Model state: frame-latched settings and a count of vsync rising edges since reset.
  logic [8:0] m_en;
  logic [1:0] m_mode;
  logic [11:0] m_col;
  logic m_ov, prev_vb, prev_vs;
  int nvs;
  out_t exp_o, pend;

  function automatic out_t predict();
    out_t o;
    int rx, ry, col, row, dx, dy;
    bit in_x, in_y, show;
    rx = int'(hcount_in);
    ry = int'(vcount_in);
    in_x = rx >= 0 && rx < N*CW && (rx % CW) >= G;
    in_y = ry >= 0 && ry < N*CH && (ry % CH) >= G;
    col = rx / CW;
    row = ry / CH;
    dx = rx % CW;
    dy = ry % CH;
    o.hc = hcount_in; o.vc = vcount_in;
    o.hs = hsync_in; o.hb = hblnk_in; o.vs = vsync_in; o.vb = vblnk_in;
    o.hit = in_x && in_y && !hblnk_in && !vblnk_in;
    o.idx = o.hit ? 4'(row*N + col) : 4'd0;
    o.rgb = rgb_in;
    if (o.hit && m_ov && m_en[row*N + col]) begin
      show = (m_mode == MODE_SOLID) ||
             (m_mode == MODE_BLINK && ((nvs / BF) % 2 == 0)) ||
             (m_mode == MODE_OUTLINE && (dx < OW || dy < OW || dx >= CW-G-OW || dy >= CH-G-OW));
      if (show) o.rgb = m_col;
    end
    return o;
  endfunction

  always @(posedge pclk) begin
    if (!rst) begin
      exp_o = '0; pend = '0;
      m_en = 0; m_mode = 0; m_col = 0; m_ov = 0;
      prev_vb = 0; prev_vs = 0; nvs = 0;
    end else begin
      exp_o = pend;
      if (vblnk_in && !prev_vb) begin
        m_en = cell_en; m_mode = mode; m_col = square_color; m_ov = start_en && !choice_en;
      end
      if (vsync_in && !prev_vs) nvs++;
      prev_vb = vblnk_in;
      prev_vs = vsync_in;
      pend = predict();
    end
  end

  always @(negedge pclk) begin
    out_t act;
    if (live) begin
      act = '{hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
              rgb_out, cell_idx_out, cell_hit_out};
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL model t=%0t got hc=%0d vc=%0d sync=%b%b%b%b rgb=%h idx=%0d hit=%b want hc=%0d vc=%0d sync=%b%b%b%b rgb=%h idx=%0d hit=%b",
                 $time, act.hc, act.vc, act.hs, act.hb, act.vs, act.vb, act.rgb, act.idx, act.hit,
                 exp_o.hc, exp_o.vc, exp_o.hs, exp_o.hb, exp_o.vs, exp_o.vb, exp_o.rgb, exp_o.idx, exp_o.hit);
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] er, input logic [3:0] ei, input logic eh);
    checks++;
    if (rgb_out !== er || cell_idx_out !== ei || cell_hit_out !== eh) begin
      errors++;
      $display("FAIL %s: got rgb=%h idx=%0d hit=%b want rgb=%h idx=%0d hit=%b",
               nm, rgb_out, cell_idx_out, cell_hit_out, er, ei, eh);
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out, cell_idx_out, cell_hit_out} !== '0) begin
      errors++;
      $display("FAIL %s: got hc=%0d vc=%0d rgb=%h idx=%0d hit=%b want all zero",
               nm, hcount_out, vcount_out, rgb_out, cell_idx_out, cell_hit_out);
    end
  endtask

  task automatic px(input int h, input int v);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = 0; hblnk_in = 0; vsync_in = 0; vblnk_in = 0;
    step();
    step();
  endtask

  task automatic frame();
    vblnk_in = 1; vsync_in = 1; hblnk_in = 1; hsync_in = 1;
    repeat (3) step();
    vsync_in = 0; hsync_in = 0;
    repeat (2) step();
    vblnk_in = 0; hblnk_in = 0;
    step();
  endtask

  logic [4:0] blink_on = 5'b11001;

  initial begin
    rgb_in = 12'h0A5; cell_en = 9'h102; mode = MODE_SOLID; square_color = 12'hF00;
    start_en = 1; choice_en = 0;
    step();
    live = 1;
    hcount_in = 700; vcount_in = 520;
    step();
    chk_zero("reset");
    rst = 1;
    px(700, 520); chk("no overlay before first vblank", 12'h0A5, 4'd8, 1'b1);
    frame();
    px(700, 520); chk("solid cell8", 12'hF00, 4'd8, 1'b1);
    px(684, 520); chk("gap col2", 12'h0A5, 4'd0, 1'b0);
    px(342, 10); chk("gap col1", 12'h0A5, 4'd0, 1'b0);
    px(345, 10); chk("cell1 first pixel", 12'hF00, 4'd1, 1'b1);
    px(1022, 10); chk("last col edge unselected", 12'h0A5, 4'd2, 1'b1);
    px(1023, 10); chk("beyond right edge", 12'h0A5, 4'd0, 1'b0);
    px(700, 767); chk("last row edge", 12'hF00, 4'd8, 1'b1);
    px(700, 768); chk("below board", 12'h0A5, 4'd0, 1'b0);
    hcount_in = 700; vcount_in = 520; hblnk_in = 1;
    step(); step(); chk("hblank no hit", 12'h0A5, 4'd0, 1'b0);
    cell_en = 9'h000; mode = MODE_OUTLINE; choice_en = 1; rgb_in = 12'h123;
    px(700, 520); chk("mid-frame change ignored", 12'hF00, 4'd8, 1'b1);
    frame();
    px(700, 520); chk("choice masks overlay", 12'h123, 4'd8, 1'b1);
    choice_en = 0; cell_en = 9'h001;
    frame();
    px(5, 100); chk("outline left", 12'hF00, 4'd0, 1'b1);
    px(100, 5); chk("outline top", 12'hF00, 4'd0, 1'b1);
    px(100, 100); chk("outline interior", 12'h123, 4'd0, 1'b1);
    px(340, 100); chk("outline right", 12'hF00, 4'd0, 1'b1);
    px(100, 240); chk("outline above bottom band", 12'h123, 4'd0, 1'b1);
    px(100, 255); chk("outline bottom", 12'hF00, 4'd0, 1'b1);
    px(2, 100); chk("outline gap", 12'h123, 4'd0, 1'b0);
    mode = MODE_OFF;
    frame();
    px(5, 100); chk("mode off", 12'h123, 4'd0, 1'b1);
    rst = 0; step(); rst = 1;
    cell_en = 9'h100; mode = MODE_BLINK;
    px(700, 520); chk("blink before vblank", 12'h123, 4'd8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      frame();
      px(700, 520);
      chk($sformatf("blink frame %0d", k + 1), blink_on[k] ? 12'hF00 : 12'h123, 4'd8, 1'b1);
    end
    mode = MODE_SOLID;
    frame();
    px(700, 520); chk("solid before reset", 12'hF00, 4'd8, 1'b1);
    rst = 0; step(); chk_zero("mid-line reset");
    rst = 1; step(); chk_zero("first cycle after reset");
    step(); chk("passthrough after reset", 12'h123, 4'd8, 1'b1);
    frame();
    px(700, 520); chk("overlay after reset vblank", 12'hF00, 4'd8, 1'b1);
    live = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
